instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the multicycle control FSM. Owns the PC, old-PC and instruction registers.

---
 rtl/ifu_pkg.sv | 27 ++
 rtl/ifu_timeout_ctr.sv | 30 +++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared fetch/control definitions: IFU state encoding, the NOP reset value of the
// instruction register and the RV32I base opcodes used by both IFU and control_fsm.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ifu_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LW     = 7'b000_0011;
  localparam logic [6:0] OP_SW     = 7'b010_0011;
  localparam logic [6:0] OP_R_TYPE = 7'b011_0011;
  localparam logic [6:0] OP_I_TYPE = 7'b001_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_BEQ    = 7'b110_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Fetch watchdog: counts enabled cycles; hit is combinational and fires on the enabled
// cycle whose increment would reach TIMEOUT, so the caller can abort on that same edge.
module ifu_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns PC/old-PC/IR, one req/ack fetch per fetch_start, ack -> instr_valid next cycle;
// stalls control while a fetch is outstanding. Define IFU_MISALIGN_CHK_EN to trap misaligned PCs.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        instr_consume,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic        stall,
  output logic        fetch_err
);

  ifu_state_t state;
  logic       misalign;
  logic       start_fetch;
  logic       tmo_en;
  logic       tmo_hit;
  logic       redir;

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign start_fetch = fetch_start & (state != WAIT);
  assign tmo_en      = (state == WAIT) & ~imem_ack;
  assign stall       = (state == WAIT) | ((state == IDLE) & fetch_start);
  assign opcode      = instr[6:0];

  ifu_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (start_fetch),
    .en    (tmo_en),
    .hit   (tmo_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      old_pc      <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      fetch_err   <= 1'b0;
      redir       <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (fetch_start) begin
            instr_valid <= 1'b0;
            redir       <= 1'b0;
            if (misalign) begin
              fetch_err <= 1'b1;
              state     <= IDLE;
            end else begin
              imem_addr <= word_align(pc);
              imem_req  <= 1'b1;
              fetch_err <= 1'b0;
              state     <= WAIT;
            end
          end else if ((state == HOLD) && instr_consume) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT: begin
          // A redirect seen while waiting must survive the ack's sequential PC update.
          if (pc_load) redir <= 1'b1;
          if (imem_ack) begin
            instr       <= imem_rdata;
            old_pc      <= imem_addr;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
            if (!redir) pc <= imem_addr + 32'd4;
          end else if (tmo_hit) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pc_load) pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetches
// against a transaction-level model of PC/IR state.
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        instr_consume = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        stall;
  logic        fetch_err;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [31:0] m_pc, m_old_pc, m_instr;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (RST_PC),
    .TIMEOUT  (TMO),
    .CNT_W    (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_start   (fetch_start),
    .instr_consume (instr_consume),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .old_pc        (old_pc),
    .stall         (stall),
    .fetch_err     (fetch_err)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_old_pc = RST_PC; m_instr = NOP_INSTR; m_valid = 1'b0; m_err = 1'b0;
  endtask

  // One complete fetch transaction; the model derives the fetch address and resulting PC.
  task automatic do_fetch(input int dly, input logic [31:0] data, input bit ld_ack, input bit ld_wait,
                          input bit poke, input logic [31:0] tgt, input bit consume);
    logic [31:0] a;
    bit lw;
    a  = {m_pc[31:2], 2'b00};
    lw = ld_wait && (dly > 0);
    fetch_start = 1'b1;
    #1;
    chk_cnt++;
    if (stall !== !m_valid) $display("FAIL start_stall: got %b exp %b", stall, !m_valid);
    else pass_cnt++;
    step();
    fetch_start = 1'b0;
    m_valid = 1'b0;
    m_err = 1'b0;
    chk_cnt++;
    if ({imem_req, imem_addr, fetch_err, instr_valid} !== {1'b1, a, 1'b0, 1'b0})
      $display("FAIL req_issue: got req=%b addr=%h err=%b vld=%b exp req=1 addr=%h err=0 vld=0",
               imem_req, imem_addr, fetch_err, instr_valid, a);
    else pass_cnt++;
    for (int i = 0; i < dly; i++) begin
      if (lw && i == 0) begin pc_load = 1'b1; pc_next = tgt; end
      if (poke && i == 1) fetch_start = 1'b1;
      step();
      pc_load = 1'b0;
      fetch_start = 1'b0;
      if (lw && i == 0) m_pc = tgt;
      chk_cnt++;
      if ({imem_req, imem_addr, stall, pc} !== {1'b1, a, 1'b1, m_pc})
        $display("FAIL wait_hold: got req=%b addr=%h stall=%b pc=%h exp req=1 addr=%h stall=1 pc=%h",
                 imem_req, imem_addr, stall, pc, a, m_pc);
      else pass_cnt++;
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    if (ld_ack) begin pc_load = 1'b1; pc_next = tgt; end
    step();
    imem_ack = 1'b0;
    pc_load = 1'b0;
    m_instr = data;
    m_old_pc = a;
    m_valid = 1'b1;
    if (ld_ack) m_pc = tgt;
    else if (!lw) m_pc = a + 32'd4;
    chk_cnt++;
    if ({instr, old_pc, pc, opcode} !== {m_instr, m_old_pc, m_pc, m_instr[6:0]})
      $display("FAIL ack_capture: got instr=%h old_pc=%h pc=%h op=%h exp instr=%h old_pc=%h pc=%h",
               instr, old_pc, pc, opcode, m_instr, m_old_pc, m_pc);
    else pass_cnt++;
    chk_cnt++;
    if ({instr_valid, imem_req, stall} !== 3'b100)
      $display("FAIL ack_flags: got vld=%b req=%b stall=%b exp vld=1 req=0 stall=0", instr_valid, imem_req, stall);
    else pass_cnt++;
    if (consume) begin
      instr_consume = 1'b1;
      step();
      instr_consume = 1'b0;
      m_valid = 1'b0;
      chk_cnt++;
      if ({instr_valid, instr} !== {1'b0, m_instr})
        $display("FAIL consume: got vld=%b instr=%h exp vld=0 instr=%h", instr_valid, instr, m_instr);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    step(); step();
    chk_cnt++;
    if ({pc, old_pc, instr, instr_valid, imem_req, imem_addr, stall, fetch_err} !==
        {RST_PC, RST_PC, NOP_INSTR, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_vals: got pc=%h old=%h instr=%h vld=%b req=%b addr=%h stall=%b err=%b exp pc=%h instr=%h rest 0",
               pc, old_pc, instr, instr_valid, imem_req, imem_addr, stall, fetch_err, RST_PC, NOP_INSTR);
    else pass_cnt++;
    reset = 1'b1;
    step();
    chk_cnt++;
    if ({imem_req, stall, instr_valid} !== 3'b000)
      $display("FAIL reset_release: got req=%b stall=%b vld=%b exp 0", imem_req, stall, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    do_fetch(2, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_cnt++;
    if ({instr, opcode, old_pc, pc, instr_valid} !== {32'h0050_0093, OP_I_TYPE, 32'h0, 32'h4, 1'b1})
      $display("FAIL basic_fetch: got instr=%h op=%h old=%h pc=%h vld=%b exp 00500093 13 0 4 1",
               instr, opcode, old_pc, pc, instr_valid);
    else pass_cnt++;
    instr_consume = 1'b1;
    step();
    instr_consume = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    n = 0;
    while (imem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    m_err = 1'b1;
    chk_cnt++;
    if (n !== TMO) $display("FAIL timeout_len: got %0d req cycles exp %0d", n, TMO);
    else pass_cnt++;
    chk_cnt++;
    if ({fetch_err, pc, instr_valid, stall} !== {m_err, m_pc, 1'b0, 1'b0})
      $display("FAIL timeout_state: got err=%b pc=%h vld=%b stall=%b exp err=1 pc=%h vld=0 stall=0",
               fetch_err, pc, instr_valid, stall, m_pc);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({fetch_err, imem_req} !== 2'b10) $display("FAIL err_sticky: got err=%b req=%b exp err=1 req=0", fetch_err, imem_req);
    else pass_cnt++;
    do_fetch(1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_pc_load_ack();
    pc_load = 1'b1;
    pc_next = 32'h8;
    step();
    pc_load = 1'b0;
    m_pc = 32'h8;
    chk_cnt++;
    if (pc !== 32'h8) $display("FAIL idle_pc_load: got %h exp 00000008", pc);
    else pass_cnt++;
    do_fetch($urandom_range(0, 5), $urandom, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1);
    chk_cnt++;
    if ({pc, old_pc} !== {32'h100, 32'h8}) $display("FAIL load_at_ack: got pc=%h old=%h exp 100 8", pc, old_pc);
    else pass_cnt++;
  endtask

  task automatic test_load_in_wait();
    logic [31:0] tgt;
    tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
    do_fetch(4, $urandom, 1'b0, 1'b1, 1'b0, tgt, 1'b1);
    chk_cnt++;
    if (pc !== tgt) $display("FAIL redirect_kept: got pc=%h exp %h", pc, tgt);
    else pass_cnt++;
    do_fetch(1, $urandom, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    pc_load = 1'b1;
    pc_next = 32'hFFFF_FFFC;
    step();
    pc_load = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    do_fetch(0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_cnt++;
    if ({pc, old_pc} !== {32'h0, 32'hFFFF_FFFC}) $display("FAIL wrap: got pc=%h old=%h exp 0 fffffffc", pc, old_pc);
    else pass_cnt++;
  endtask

  task automatic test_ignored();
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    instr_consume = 1'b1;
    step();
    imem_ack = 1'b0;
    instr_consume = 1'b0;
    chk_cnt++;
    if ({instr, instr_valid, imem_req, pc} !== {m_instr, 1'b0, 1'b0, m_pc})
      $display("FAIL idle_ack_ignored: got instr=%h vld=%b req=%b pc=%h exp instr=%h vld=0 req=0 pc=%h",
               instr, instr_valid, imem_req, pc, m_instr, m_pc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_fetch($urandom_range(0, 3), $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch($urandom_range(0, 3), $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_fetch(2, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid_wait();
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_cnt++;
    if ({imem_req, imem_addr, pc, old_pc, instr, instr_valid, stall, fetch_err} !==
        {1'b0, 32'h0, RST_PC, RST_PC, NOP_INSTR, 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset: got req=%b addr=%h pc=%h old=%h instr=%h vld=%b stall=%b err=%b exp reset values",
               imem_req, imem_addr, pc, old_pc, instr, instr_valid, stall, fetch_err);
    else pass_cnt++;
    step();
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk_cnt++;
    if ({instr, instr_valid, imem_req, pc} !== {NOP_INSTR, 1'b0, 1'b0, RST_PC})
      $display("FAIL stray_ack: got instr=%h vld=%b req=%b pc=%h exp instr=%h vld=0 req=0 pc=%h",
               instr, instr_valid, imem_req, pc, NOP_INSTR, RST_PC);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    pc_load = 1'b1;
    pc_next = 32'h102;
    step();
    pc_load = 1'b0;
    m_pc = 32'h102;
`ifdef IFU_MISALIGN_CHK_EN
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    chk_cnt++;
    if ({imem_req, fetch_err, stall, pc} !== {1'b0, 1'b1, 1'b0, 32'h102})
      $display("FAIL misalign_trap: got req=%b err=%b stall=%b pc=%h exp req=0 err=1 stall=0 pc=102",
               imem_req, fetch_err, stall, pc);
    else pass_cnt++;
    pc_load = 1'b1;
    pc_next = 32'h100;
    step();
    pc_load = 1'b0;
    m_pc = 32'h100;
`else
    do_fetch(1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_cnt++;
    if ({old_pc, pc} !== {32'h100, 32'h104}) $display("FAIL misalign_force: got old=%h pc=%h exp 100 104", old_pc, pc);
    else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int k = 0; k < 30; k++) begin
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'hFFFF), 2'b00};
      do_fetch($urandom_range(0, 12), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)));
    end
    if (m_valid) begin
      instr_consume = 1'b1;
      step();
      instr_consume = 1'b0;
      m_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_pc_load_ack();
    test_load_in_wait();
    test_wrap();
    test_ignored();
    test_back_to_back();
    test_reset_mid_wait();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
